// File: rtl/line_scan_sequencer.sv
// Line readout sequencer for a TSL1401-class linear sensor through an LTC2308 controller:
// SI/CLK generation, one ADC capture per pixel, pixel streaming and per-line min/max.
module line_scan_sequencer #(
   parameter int unsigned NUM_PIXELS  = 128,
   parameter int unsigned CLK_DIV     = 20,
   parameter int unsigned ADC_TIMEOUT = 4095,
   localparam int unsigned IDX_W      = $clog2(NUM_PIXELS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             continuous,
   input  logic [23:0]      exposure_cycles,
   output logic             busy,
   output logic             cam_si,
   output logic             cam_clk,
   output logic             adc_capture,
   input  logic             adc_ready,
   input  logic [11:0]      adc_data,
   output logic             pix_valid,
   output logic [IDX_W-1:0] pix_index,
   output logic [11:0]      pix_data,
   output logic             line_done,
   output logic [11:0]      line_min,
   output logic [11:0]      line_max,
   output logic [IDX_W-1:0] line_min_idx,
   output logic [IDX_W-1:0] line_max_idx,
   output logic             adc_error
);

   localparam int unsigned PH_W = 16;

   typedef enum logic [3:0] {
      IDLE, SI_SETUP, CLK_HIGH, ADC_START, ADC_WAIT, EMIT,
      CLK_LOW, END_HIGH, END_LOW, EXPOSE, DONE
   } state_t;

   state_t             state_q, state_d;
   logic [PH_W-1:0]    phase_q, phase_d;
   logic [23:0]        exp_q, exp_d;
   logic [23:0]        exp_cnt_q, exp_cnt_d;
   logic [IDX_W-1:0]   pix_cnt_q, pix_cnt_d;
   logic [11:0]        run_min_q, run_min_d, run_max_q, run_max_d;
   logic [IDX_W-1:0]   run_min_idx_q, run_min_idx_d, run_max_idx_q, run_max_idx_d;
   logic               ready_q;
   logic               busy_q, busy_d, cam_si_q, cam_si_d, cam_clk_q, cam_clk_d;
   logic               adc_capture_q, adc_capture_d, pix_valid_q, pix_valid_d;
   logic [IDX_W-1:0]   pix_index_q, pix_index_d;
   logic [11:0]        pix_data_q, pix_data_d;
   logic               line_done_q, line_done_d;
   logic [11:0]        line_min_q, line_min_d, line_max_q, line_max_d;
   logic [IDX_W-1:0]   line_min_idx_q, line_min_idx_d, line_max_idx_q, line_max_idx_d;
   logic               adc_error_q, adc_error_d;

   logic               phase_last, ready_edge, begin_line, sample;
   logic [11:0]        sample_val;

   assign phase_last = (phase_q == PH_W'(CLK_DIV - 1));
   assign ready_edge = adc_ready & ~ready_q;

   // Next-state, datapath and registered-output computation.
   always_comb begin
      state_d        = state_q;
      exp_d          = exp_q;
      pix_cnt_d      = pix_cnt_q;
      run_min_d      = run_min_q;
      run_max_d      = run_max_q;
      run_min_idx_d  = run_min_idx_q;
      run_max_idx_d  = run_max_idx_q;
      pix_valid_d    = 1'b0;
      pix_index_d    = pix_index_q;
      pix_data_d     = pix_data_q;
      line_done_d    = 1'b0;
      line_min_d     = line_min_q;
      line_max_d     = line_max_q;
      line_min_idx_d = line_min_idx_q;
      line_max_idx_d = line_max_idx_q;
      adc_error_d    = adc_error_q;
      begin_line     = 1'b0;
      sample         = 1'b0;
      sample_val     = 12'd0;

      case (state_q)
         IDLE: if (start) begin
            begin_line = 1'b1;
            state_d    = SI_SETUP;
         end
         SI_SETUP:  if (phase_last) state_d = CLK_HIGH;
         CLK_HIGH:  if (phase_last) state_d = ADC_START;
         ADC_START: state_d = ADC_WAIT;
         ADC_WAIT: begin
            if (ready_edge) begin
               sample     = 1'b1;
               sample_val = adc_data;
               state_d    = EMIT;
            end else if (phase_q == PH_W'(ADC_TIMEOUT - 1)) begin
               sample      = 1'b1;
               adc_error_d = 1'b1;
               state_d     = EMIT;
            end
         end
         EMIT: state_d = CLK_LOW;
         CLK_LOW: if (phase_last) begin
            if (pix_cnt_q == IDX_W'(NUM_PIXELS - 1)) begin
               state_d = END_HIGH;
            end else begin
               pix_cnt_d = pix_cnt_q + IDX_W'(1);
               state_d   = CLK_HIGH;
            end
         end
         END_HIGH: if (phase_last) state_d = END_LOW;
         END_LOW:  if (phase_last) state_d = (exp_q == 24'd0) ? DONE : EXPOSE;
         EXPOSE:   if (exp_cnt_q == exp_q - 24'd1) state_d = DONE;
         DONE: begin
            if (continuous) begin
               begin_line = 1'b1;
               state_d    = SI_SETUP;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (begin_line) begin
         exp_d         = exposure_cycles;
         adc_error_d   = 1'b0;
         pix_cnt_d     = '0;
         run_min_d     = 12'hFFF;
         run_max_d     = 12'h000;
         run_min_idx_d = '0;
         run_max_idx_d = '0;
      end

      // Strict compares so ties keep the earliest index.
      if (sample) begin
         pix_valid_d = 1'b1;
         pix_index_d = pix_cnt_q;
         pix_data_d  = sample_val;
         if (sample_val < run_min_q) begin
            run_min_d     = sample_val;
            run_min_idx_d = pix_cnt_q;
         end
         if (sample_val > run_max_q) begin
            run_max_d     = sample_val;
            run_max_idx_d = pix_cnt_q;
         end
      end

      if (state_d == DONE && state_q != DONE) begin
         line_done_d    = 1'b1;
         line_min_d     = run_min_q;
         line_max_d     = run_max_q;
         line_min_idx_d = run_min_idx_q;
         line_max_idx_d = run_max_idx_q;
      end

      phase_d       = (state_d != state_q) ? '0 : phase_q + PH_W'(1);
      exp_cnt_d     = (state_q == EXPOSE) ? exp_cnt_q + 24'd1 : 24'd0;
      busy_d        = (state_d != IDLE);
      cam_si_d      = (state_d == SI_SETUP) || (state_d == CLK_HIGH && pix_cnt_d == '0);
      cam_clk_d     = (state_d == CLK_HIGH) || (state_d == ADC_START) || (state_d == ADC_WAIT) ||
                      (state_d == EMIT) || (state_d == END_HIGH);
      adc_capture_d = (state_d == ADC_START);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         phase_q        <= '0;
         exp_q          <= '0;
         exp_cnt_q      <= '0;
         pix_cnt_q      <= '0;
         run_min_q      <= 12'hFFF;
         run_max_q      <= 12'h000;
         run_min_idx_q  <= '0;
         run_max_idx_q  <= '0;
         ready_q        <= 1'b0;
         busy_q         <= 1'b0;
         cam_si_q       <= 1'b0;
         cam_clk_q      <= 1'b0;
         adc_capture_q  <= 1'b0;
         pix_valid_q    <= 1'b0;
         pix_index_q    <= '0;
         pix_data_q     <= 12'd0;
         line_done_q    <= 1'b0;
         line_min_q     <= 12'hFFF;
         line_max_q     <= 12'h000;
         line_min_idx_q <= '0;
         line_max_idx_q <= '0;
         adc_error_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         phase_q        <= phase_d;
         exp_q          <= exp_d;
         exp_cnt_q      <= exp_cnt_d;
         pix_cnt_q      <= pix_cnt_d;
         run_min_q      <= run_min_d;
         run_max_q      <= run_max_d;
         run_min_idx_q  <= run_min_idx_d;
         run_max_idx_q  <= run_max_idx_d;
         ready_q        <= adc_ready;
         busy_q         <= busy_d;
         cam_si_q       <= cam_si_d;
         cam_clk_q      <= cam_clk_d;
         adc_capture_q  <= adc_capture_d;
         pix_valid_q    <= pix_valid_d;
         pix_index_q    <= pix_index_d;
         pix_data_q     <= pix_data_d;
         line_done_q    <= line_done_d;
         line_min_q     <= line_min_d;
         line_max_q     <= line_max_d;
         line_min_idx_q <= line_min_idx_d;
         line_max_idx_q <= line_max_idx_d;
         adc_error_q    <= adc_error_d;
      end
   end

   assign busy         = busy_q;
   assign cam_si       = cam_si_q;
   assign cam_clk      = cam_clk_q;
   assign adc_capture  = adc_capture_q;
   assign pix_valid    = pix_valid_q;
   assign pix_index    = pix_index_q;
   assign pix_data     = pix_data_q;
   assign line_done    = line_done_q;
   assign line_min     = line_min_q;
   assign line_max     = line_max_q;
   assign line_min_idx = line_min_idx_q;
   assign line_max_idx = line_max_idx_q;
   assign adc_error    = adc_error_q;

endmodule

// File: tb/tb_line_scan_sequencer.sv
// Directed bench for line_scan_sequencer: 8-pixel lines against a simple LTC2308 ready/data model.
module tb_line_scan_sequencer;

   logic        clk = 1'b0;
   logic        reset, start, continuous;
   logic [23:0] exposure_cycles;
   logic        busy, cam_si, cam_clk, adc_capture, adc_ready, pix_valid, line_done, adc_error;
   logic [11:0] adc_data, pix_data, line_min, line_max;
   logic [2:0]  pix_index, line_min_idx, line_max_idx;

   line_scan_sequencer #(.NUM_PIXELS(8), .CLK_DIV(4), .ADC_TIMEOUT(4095)) dut (
      .clk(clk), .reset(reset), .start(start), .continuous(continuous),
      .exposure_cycles(exposure_cycles), .busy(busy), .cam_si(cam_si), .cam_clk(cam_clk),
      .adc_capture(adc_capture), .adc_ready(adc_ready), .adc_data(adc_data),
      .pix_valid(pix_valid), .pix_index(pix_index), .pix_data(pix_data),
      .line_done(line_done), .line_min(line_min), .line_max(line_max),
      .line_min_idx(line_min_idx), .line_max_idx(line_max_idx), .adc_error(adc_error)
   );

   always #5 clk = ~clk;

   // ADC model knobs, written only by the stimulus block.
   int hang_idx   = -1;
   int data_const = -1;
   bit stale_mode = 1'b0;
   bit pre_high   = 1'b0;

   int cnt = 0, cur = 0, cap_num = 0;
   initial begin
      adc_ready = 1'b0;
      adc_data  = 12'd0;
   end

   // Ready drops one cycle after capture and rises ten cycles after it.
   always @(posedge clk) begin
      if (reset || line_done) cap_num <= 0;
      if (pre_high) adc_ready <= 1'b1;
      if (adc_capture) begin
         cnt       <= 1;
         cur       <= cap_num;
         cap_num   <= cap_num + 1;
         adc_ready <= (stale_mode && cap_num == 0);
      end else if (cnt != 0) begin
         cnt <= cnt + 1;
         if (cnt == 3 && stale_mode && cur == 0) adc_ready <= 1'b0;
         if (cnt == 9) begin
            cnt <= 0;
            if (cur != hang_idx) begin
               adc_ready <= 1'b1;
               adc_data  <= (data_const >= 0) ? 12'(data_const) : 12'(100 * cur + 5);
            end
         end
      end
   end

   // Observation of DUT outputs, away from the active edge.
   int cyc = 0, pv_n = 0, rises = 0, si_cnt = 0, ld_n = 0, busy_start = 0, busy_low = 0;
   int pv_idx [128];
   int pv_dat [128];
   int ld_c   [32];
   logic clk_prev = 1'b0, busy_prev = 1'b0;
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (pix_valid && pv_n < 128) begin
         pv_idx[pv_n] = int'(pix_index);
         pv_dat[pv_n] = int'(pix_data);
         pv_n = pv_n + 1;
      end
      if (cam_clk && !clk_prev) rises = rises + 1;
      clk_prev = cam_clk;
      if (cam_si) si_cnt = si_cnt + 1;
      if (busy && !busy_prev) busy_start = cyc;
      if (!busy) busy_low = busy_low + 1;
      busy_prev = busy;
      if (line_done && ld_n < 32) begin
         ld_c[ld_n] = cyc;
         ld_n = ld_n + 1;
      end
   end

   int n_chk = 0, n_fail = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk = n_chk + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string tag);
      int base;
      bit ok;
      base = ld_n;
      ok   = 1'b0;
      for (int k = 0; k < budget && !ok; k++) begin
         tick();
         if (ld_n > base) ok = 1'b1;
      end
      check({tag, "_done_seen"}, 32'(ok), 32'd1);
   endtask

   task automatic check_pixels(input string tag, input int base, input int hang);
      check({tag, "_pix_count"}, 32'(pv_n - base), 32'd8);
      for (int i = 0; i < 8; i++) begin
         check({tag, "_pix_idx"}, 32'(pv_idx[base + i]), 32'(i));
         check({tag, "_pix_data"}, 32'(pv_dat[base + i]), (i == hang) ? 32'd0 : 32'(100 * i + 5));
      end
   endtask

   initial begin
      int pv_base, rise_base, si_base, ld1, ld_base, bl_base;
      reset = 1'b1; start = 1'b0; continuous = 1'b0; exposure_cycles = 24'd0;
      repeat (3) tick();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_cam", 32'({cam_si, cam_clk, adc_capture, pix_valid, line_done}), 32'd0);
      check("rst_min", 32'(line_min), 32'hFFF);
      check("rst_max", 32'(line_max), 32'd0);
      check("rst_err", 32'(adc_error), 32'd0);
      reset = 1'b0;
      repeat (2) tick();

      // Single line, exposure 0.
      pv_base = pv_n; rise_base = rises; si_base = si_cnt;
      pulse_start();
      check("t1_busy_next", 32'(busy), 32'd1);
      check("t1_si_next", 32'(cam_si), 32'd1);
      wait_done(500, "t1");
      check_pixels("t1", pv_base, -1);
      check("t1_rises", 32'(rises - rise_base), 32'd9);
      check("t1_si_cycles", 32'(si_cnt - si_base), 32'd8);
      check("t1_min", 32'(line_min), 32'd5);
      check("t1_min_idx", 32'(line_min_idx), 32'd0);
      check("t1_max", 32'(line_max), 32'd705);
      check("t1_max_idx", 32'(line_max_idx), 32'd7);
      check("t1_length", 32'(ld_c[ld_n - 1] - busy_start + 1), 32'd173);
      check("t1_err", 32'(adc_error), 32'd0);
      tick();
      check("t1_done_strobe", 32'(line_done), 32'd0);
      check("t1_idle", 32'(busy), 32'd0);

      // Timeout on pixel 3.
      hang_idx = 3;
      pv_base = pv_n;
      pulse_start();
      wait_done(6000, "t2");
      check_pixels("t2", pv_base, 3);
      check("t2_err", 32'(adc_error), 32'd1);
      check("t2_min", 32'(line_min), 32'd0);
      check("t2_min_idx", 32'(line_min_idx), 32'd3);
      check("t2_max", 32'(line_max), 32'd705);
      check("t2_length", 32'(ld_c[ld_n - 1] - busy_start + 1), 32'd4258);
      hang_idx = -1;
      repeat (3) tick();

      // Equal data with ready already high before the first capture.
      data_const = 12'h800; stale_mode = 1'b1; pre_high = 1'b1;
      repeat (3) tick();
      pre_high = 1'b0;
      pv_base = pv_n;
      pulse_start();
      tick();
      check("t3_err_cleared", 32'(adc_error), 32'd0);
      wait_done(500, "t3");
      check("t3_pix_count", 32'(pv_n - pv_base), 32'd8);
      check("t3_min", 32'(line_min), 32'h800);
      check("t3_min_idx", 32'(line_min_idx), 32'd0);
      check("t3_max", 32'(line_max), 32'h800);
      check("t3_max_idx", 32'(line_max_idx), 32'd0);
      check("t3_length", 32'(ld_c[ld_n - 1] - busy_start + 1), 32'd173);
      data_const = -1; stale_mode = 1'b0;
      repeat (3) tick();

      // Continuous with exposure 50; mid-line starts and exposure changes have no effect.
      exposure_cycles = 24'd50; continuous = 1'b1;
      pulse_start();
      wait_done(600, "t4a");
      ld1 = ld_c[ld_n - 1];
      bl_base = busy_low; pv_base = pv_n;
      repeat (20) tick();
      exposure_cycles = 24'd0;
      start = 1'b1;
      repeat (5) tick();
      start = 1'b0;
      wait_done(600, "t4b");
      continuous = 1'b0;
      check("t4_gap", 32'(ld_c[ld_n - 1] - ld1), 32'd223);
      check("t4_no_idle", 32'(busy_low - bl_base), 32'd0);
      check("t4_pix_count", 32'(pv_n - pv_base), 32'd8);
      check("t4_max", 32'(line_max), 32'd705);
      tick();
      check("t4_stop_idle", 32'(busy), 32'd0);
      repeat (3) tick();

      // Reset during pixel 4 ADC_WAIT.
      pv_base = pv_n;
      pulse_start();
      for (int k = 0; k < 400 && pv_n < pv_base + 4; k++) tick();
      for (int k = 0; k < 50 && !adc_capture; k++) tick();
      check("t5_reached_px4", 32'(adc_capture), 32'd1);
      repeat (3) tick();
      reset = 1'b1;
      tick();
      check("t5_busy", 32'(busy), 32'd0);
      check("t5_cam", 32'({cam_si, cam_clk, adc_capture, pix_valid, line_done}), 32'd0);
      check("t5_pix", 32'({9'd0, pix_index, 8'd0, pix_data}), 32'd0);
      check("t5_min", 32'(line_min), 32'hFFF);
      check("t5_max", 32'({line_max, line_min_idx, line_max_idx}), 32'd0);
      tick();
      reset = 1'b0;
      ld_base = ld_n;
      repeat (200) tick();
      check("t5_no_done", 32'(ld_n - ld_base), 32'd0);
      pv_base = pv_n;
      pulse_start();
      wait_done(500, "t5");
      check_pixels("t5", pv_base, -1);
      check("t5_length", 32'(ld_c[ld_n - 1] - busy_start + 1), 32'd173);
      check("t5_min_after", 32'(line_min), 32'd5);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/line_scan_sequencer.md
# line_scan_sequencer

Sequences one line readout of the TSL1401-class linear image sensor through the LTC2308 ADC controller. It generates the sensor SI/CLK waveforms and fires one ADC capture per pixel. It waits for each conversion, streams the pixels out with their index, and reports per-line min/max statistics. It sits between the camera pins, the LTC2308 controller (data_capture/data_ready/selected channel), and the downstream line-processing logic.

## Interface
- NUM_PIXELS, 128: pixels per line; index width is clog2(NUM_PIXELS).
- CLK_DIV, 20: clk cycles per half period of cam_clk; must be at least 2.
- ADC_TIMEOUT, 4095: maximum clk cycles spent waiting for a conversion.
- clk  in  1  system clock, max 40 MHz (shared with the ADC controller).
- reset  in  1  synchronous, active-high.
- start  in  1  level; sampled only in IDLE; a high sample begins a line.
- continuous  in  1  sampled in DONE; if high, the next line starts without start.
- exposure_cycles  in  24  extra integration wait after a line; latched when a line begins.
- busy  out  1  high in every state except IDLE.
- cam_si  out  1  sensor SI.
- cam_clk  out  1  sensor CLK.
- adc_capture  out  1  to ADC data_capture; one-cycle high pulse per pixel.
- adc_ready  in  1  ADC data_ready.
- adc_data  in  12  ADC result for the camera channel.
- pix_valid  out  1  one-cycle strobe per pixel.
- pix_index  out  IDX  pixel number, 0..NUM_PIXELS-1.
- pix_data  out  12  pixel value.
- line_done  out  1  one-cycle strobe after the line completes.
- line_min, line_max  out  12  extreme pixel values of the last completed line.
- line_min_idx, line_max_idx  out  IDX  index of the first occurrence of each extreme.
- adc_error  out  1  sticky; set on any timeout; cleared when a line begins.

## Operation
- States: IDLE, SI_SETUP, CLK_HIGH, ADC_START, ADC_WAIT, EMIT, CLK_LOW, END_HIGH, END_LOW, EXPOSE, DONE.
- A 16-bit phase counter times each CLK_DIV state and restarts on every state entry.
- IDLE, start high: latch exposure_cycles, clear adc_error, set pixel counter to 0, set running min to 0xFFF and running max to 0. Go to SI_SETUP.
- SI_SETUP (CLK_DIV cycles): cam_si=1, cam_clk=0.
- CLK_HIGH (CLK_DIV cycles): cam_clk=1. cam_si=1 only for pixel 0, otherwise 0. The high time doubles as analog settle time.
- ADC_START (1 cycle): adc_capture=1; adc_ready edge detector is armed.
- ADC_WAIT: cam_clk stays 1. Exit on the first rising edge of adc_ready, i.e. the registered previous value is 0 and the current value is 1. A level that is already high does not count.
- ADC_WAIT timeout: after ADC_TIMEOUT cycles with no edge, set adc_error; the pixel value becomes 0.
- EMIT (1 cycle): pix_valid=1 with pix_index and pix_data (adc_data, or 0 on timeout). Update the running min/max; ties keep the earlier index.
- CLK_LOW (CLK_DIV cycles): cam_clk=0.
  - If this is the last pixel, go to END_HIGH.
  - Otherwise increment the pixel counter and go to CLK_HIGH.
- END_HIGH / END_LOW (CLK_DIV cycles each): the 129th terminating clock pulse; no ADC capture.
- EXPOSE: wait the latched exposure_cycles; a value of 0 spends 0 cycles and goes straight to DONE.
- DONE (1 cycle): line_done=1, and the line_min/max outputs take the running values in the same cycle.
  - If continuous is high, re-latch exposure, clear adc_error and go to SI_SETUP.
  - Otherwise go to IDLE.
- start is ignored while busy.

## Timing
- Reset values: busy=0, cam_si=0, cam_clk=0, adc_capture=0, pix_valid=0, pix_index=0, pix_data=0, line_done=0, line_min=0xFFF, line_max=0, both idx=0, adc_error=0. State returns to IDLE.
- Reset mid-line: the next edge forces the reset values and drops the partial line; no line_done is emitted. The next line's SI restarts the sensor.
- All outputs are registered.
- start sampled high in IDLE → busy and cam_si high on the next cycle.
- cam_clk rises CLK_DIV cycles after cam_si rises; cam_si falls CLK_DIV cycles after cam_clk rises (SI hold equals the half period).
- adc_capture fires exactly CLK_DIV cycles after each cam_clk rise.
- ready edge seen in cycle t → pix_valid asserted in cycle t+1 → cam_clk falls in cycle t+2.
- Pixel period = 2·CLK_DIV + 2 + W, where W is the ADC_WAIT duration including the edge cycle.
- Line length = CLK_DIV + NUM_PIXELS·(2·CLK_DIV+2+W) + 2·CLK_DIV + exposure_cycles + 1, measured from the first busy cycle to the line_done cycle inclusive.

## Test plan
- Bench settings: CLK_DIV=4, NUM_PIXELS=8. The ADC model drops ready 1 cycle after capture and raises it 10 cycles after capture, returning data = 100·index+5.
- Single line, exposure 0: 8 pix_valid with indices 0..7 and data 5,105,…,705. There are 9 cam_clk rises and cam_si is high for exactly 8 cycles. line_done arrives with line_min=5@0 and line_max=705@7. Line length = 4+8·(10+10)+8+0+1 = 173 cycles.
- Timeout: the model never raises ready for pixel 3. adc_error sets, pixel 3 is emitted with data 0 after 4095 wait cycles, line_min=0@3, and the remaining pixels are normal.
- Ties and stale ready: all data = 0x800 and adc_ready is held high before the first capture. Expect min/max idx both 0, and no capture is accepted until a true rising edge.
- Continuous: continuous=1 with exposure 50. DONE leads back to SI_SETUP with no IDLE cycle; the gap between consecutive line_done strobes is 173+50 cycles; start pulses mid-line have no effect.
- Reset mid-line: assert reset during pixel 4's ADC_WAIT. All outputs are at reset values on the next cycle, no line_done appears, and a following start produces a clean 8-pixel line.
